// File: rtl/sev_seg_scan_ctrl.sv
// sev_seg_scan_ctrl
// Multiplexed four-digit seven-segment scan controller. Each digit is lit for
// DIV cycles, then all digits are dark for BLANK_CYC cycles, cycling digits
// 0..3. Segment patterns come from a hex decoder applied to a shadow register
// that is only updated in IDLE or on the digit 3 -> 0 wrap, so a frame never
// shows mixed data.
//
// Parameters:
//   DIV        cycles each digit is lit        (2..65535)
//   BLANK_CYC  dark cycles between digits      (1..255)
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         1 = scan, 0 = display dark (IDLE)
//   data       four hex digits, digit k = data[4k+3:4k]
//   dp_in      decimal point per digit
//   load_req   level request to capture data/dp_in
//   load_ack   one-cycle capture pulse
//   a..g, dot  segment / decimal-point drives, active-high
//   an         digit enables, active-low
//   frame_done one-cycle pulse when digit 3 finishes its blank phase
// Optional feature:
//   SEV_SEG_LZB_EN  leading-zero blanking of digits above the highest
//                   nonzero digit (digit 0 always decoded).
module sev_seg_scan_ctrl #(
  parameter int unsigned DIV       = 1000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic        load_req,
  output logic        load_ack,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic        dot,
  output logic [3:0]  an,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] shd_data, shd_data_nxt;
  logic [3:0]  shd_dp, shd_dp_nxt;
  logic        armed, armed_nxt;
  logic        capture, wrap, fd_nxt;
  logic [3:0]  an_nxt;
  logic [6:0]  seg_nxt, seg_q;
  logic        dot_nxt;
  logic [3:0]  cur_digit;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Sequencing: en low overrides everything and parks in IDLE.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    wrap      = 1'b0;
    fd_nxt    = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = 2'd0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SHOW;
          idx_nxt   = 2'd0;
          cnt_nxt   = '0;
        end
        SHOW: begin
          if (cnt == DIV_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
            idx_nxt   = idx + 2'd1;
            if (idx == 2'd3) begin
              wrap   = 1'b1;
              fd_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = 2'd0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Capture handshake: a held request is acknowledged once, then load_req
  // must be observed low before the next one re-arms.
  always_comb begin
    capture      = load_req && armed && ((state == IDLE) || wrap);
    shd_data_nxt = capture ? data  : shd_data;
    shd_dp_nxt   = capture ? dp_in : shd_dp;
    if (capture)        armed_nxt = 1'b0;
    else if (!load_req) armed_nxt = 1'b1;
    else                armed_nxt = armed;
  end

  // Outputs are decoded from next-cycle state and shadow so that the
  // registered drives line up with the state they describe, including the
  // first digit of a frame whose data was captured on the same edge.
  always_comb begin
    an_nxt    = '1;
    seg_nxt   = '0;
    dot_nxt   = 1'b0;
    cur_digit = shd_data_nxt[{idx_nxt, 2'b00} +: 4];
    if (state_nxt == SHOW) begin
      an_nxt[idx_nxt] = 1'b0;
      dot_nxt         = shd_dp_nxt[idx_nxt];
`ifdef SEV_SEG_LZB_EN
      if ((idx_nxt != 2'd0) && ((shd_data_nxt >> {idx_nxt, 2'b00}) == 16'd0))
        seg_nxt = '0;
      else
        seg_nxt = hex_decode(cur_digit);
`else
      seg_nxt = hex_decode(cur_digit);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= '0;
      shd_data   <= '0;
      shd_dp     <= '0;
      armed      <= 1'b1;
      an         <= '1;
      seg_q      <= '0;
      dot        <= 1'b0;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      shd_data   <= shd_data_nxt;
      shd_dp     <= shd_dp_nxt;
      armed      <= armed_nxt;
      an         <= an_nxt;
      seg_q      <= seg_nxt;
      dot        <= dot_nxt;
      load_ack   <= capture;
      frame_done <= fd_nxt;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
module tb_sev_seg_scan_ctrl;

  localparam int unsigned P_DIV   = 4;
  localparam int unsigned P_BLANK = 2;
  localparam int unsigned FRAME   = 4 * (P_DIV + P_BLANK);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic        load_req = 1'b0;
  logic        load_ack;
  logic        a, b, c, d, e, f, g, dot, frame_done;
  logic [3:0]  an;

  int total = 0;
  int bad = 0;

  // {an[3:0], a..g, dot, frame_done, load_ack}
  logic [13:0] sb[$];
  logic [13:0] obs, expv;

  logic [6:0] seg_tbl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  sev_seg_scan_ctrl #(.DIV(P_DIV), .BLANK_CYC(P_BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data), .dp_in(dp_in),
    .load_req(load_req), .load_ack(load_ack),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .dot(dot), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [6:0] exp_seg(input logic [15:0] val, input int k);
    logic [3:0] dig;
    dig = val[4*k +: 4];
`ifdef SEV_SEG_LZB_EN
    if (k != 0 && (val >> (4*k)) == 16'd0) return 7'b0000000;
`endif
    return seg_tbl[dig];
  endfunction

  // Expected frame: digit k lit P_DIV cycles, then P_BLANK dark cycles.
  task automatic push_frame(input logic [15:0] val, input logic [3:0] dp,
                            input logic fd0, input logic ack0);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < int'(P_DIV); j++) begin
        logic [3:0] an_e;
        an_e = 4'b1111;
        an_e[k] = 1'b0;
        sb.push_back({an_e, exp_seg(val, k), dp[k],
                      (k == 0 && j == 0) ? fd0 : 1'b0,
                      (k == 0 && j == 0) ? ack0 : 1'b0});
      end
      for (int j = 0; j < int'(P_BLANK); j++)
        sb.push_back({4'b1111, 7'b0, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    load_req = 1'b1;
    data = 16'hFFFF;
    cyc();
    obs = {an, a, b, c, d, e, f, g, dot, frame_done, load_ack};
    total++;
    if (obs !== {4'b1111, 10'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got %h want %h", obs, {4'b1111, 10'b0});
    end
    en = 1'b0;
    load_req = 1'b0;
    data = '0;
    rst_n = 1'b1;
    cyc();
    obs = {an, a, b, c, d, e, f, g, dot, frame_done, load_ack};
    total++;
    if (obs !== {4'b1111, 10'b0}) begin
      bad++;
      $display("FAIL idle_after_reset: got %h want %h", obs, {4'b1111, 10'b0});
    end
  endtask

  task automatic test_load_idle();
    data = 16'h12AF;
    dp_in = 4'b0000;
    load_req = 1'b1;
    cyc();
    total++;
    if (load_ack !== 1'b1) begin
      bad++;
      $display("FAIL idle_load_ack: got %b want 1", load_ack);
    end
    total++;
    if (an !== 4'b1111) begin
      bad++;
      $display("FAIL idle_dark: an got %b want 1111", an);
    end
    load_req = 1'b0;
    cyc();
    total++;
    if (load_ack !== 1'b0) begin
      bad++;
      $display("FAIL ack_one_cycle: got %b want 0", load_ack);
    end
  endtask

  task automatic test_scan();
    en = 1'b1;
    push_frame(16'h12AF, 4'b0000, 1'b0, 1'b0);
    push_frame(16'h12AF, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < int'(2 * FRAME); i++) begin
      cyc();
      obs = {an, a, b, c, d, e, f, g, dot, frame_done, load_ack};
      expv = sb.pop_front();
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL scan_12AF cyc%0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_midframe_load();
    // Frame 3 shows old data while a request is pending; new data only at wrap.
    push_frame(16'h12AF, 4'b0000, 1'b1, 1'b0);
    push_frame(16'h0005, 4'b0101, 1'b1, 1'b1);
    push_frame(16'h0005, 4'b0101, 1'b1, 1'b0);
    for (int i = 0; i < int'(3 * FRAME); i++) begin
      if (i == 5) begin
        data = 16'h0005;
        dp_in = 4'b0101;
        load_req = 1'b1;
      end
      if (i == int'(FRAME) + 3) begin
        // still requesting with changed data: must not be re-acknowledged
        data = 16'h3333;
        dp_in = 4'b1111;
      end
      cyc();
      obs = {an, a, b, c, d, e, f, g, dot, frame_done, load_ack};
      expv = sb.pop_front();
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL midframe_load cyc%0d: got %h want %h", i, obs, expv);
      end
    end
    load_req = 1'b0;
  endtask

  task automatic test_en_drop();
    push_frame(16'h0005, 4'b0101, 1'b1, 1'b0);
    // digit0 + blank + digit1 + blank, then first cycle of digit 2
    for (int i = 0; i < int'(2 * (P_DIV + P_BLANK)) + 1; i++) begin
      cyc();
      obs = {an, a, b, c, d, e, f, g, dot, frame_done, load_ack};
      expv = sb.pop_front();
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL pre_drop cyc%0d: got %h want %h", i, obs, expv);
      end
    end
    sb.delete();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      obs = {an, a, b, c, d, e, f, g, dot, frame_done, load_ack};
      total++;
      if (obs !== {4'b1111, 10'b0}) begin
        bad++;
        $display("FAIL en_drop_dark cyc%0d: got %h want %h", i, obs, {4'b1111, 10'b0});
      end
    end
    en = 1'b1;
    push_frame(16'h0005, 4'b0101, 1'b0, 1'b0);
    for (int i = 0; i < int'(FRAME); i++) begin
      cyc();
      obs = {an, a, b, c, d, e, f, g, dot, frame_done, load_ack};
      expv = sb.pop_front();
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL reenable cyc%0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_async_reset();
    push_frame(16'h0005, 4'b0101, 1'b1, 1'b0);
    for (int i = 0; i < int'(P_DIV) + 1; i++) begin
      cyc();
      obs = {an, a, b, c, d, e, f, g, dot, frame_done, load_ack};
      expv = sb.pop_front();
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL pre_reset cyc%0d: got %h want %h", i, obs, expv);
      end
    end
    sb.delete();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    obs = {an, a, b, c, d, e, f, g, dot, frame_done, load_ack};
    total++;
    if (obs !== {4'b1111, 10'b0}) begin
      bad++;
      $display("FAIL async_reset: got %h want %h", obs, {4'b1111, 10'b0});
    end
    cyc();
    rst_n = 1'b1;
    // shadow cleared by reset: frame restarts at digit 0 showing zeros
    push_frame(16'h0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < int'(FRAME); i++) begin
      cyc();
      obs = {an, a, b, c, d, e, f, g, dot, frame_done, load_ack};
      expv = sb.pop_front();
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL post_reset cyc%0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_idle();
    test_scan();
    test_midframe_load();
    test_en_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sev_seg_scan_ctrl.md
SEV_SEG_SCAN_CTRL -- requirements
Module: sev_seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 1000, giving the clock cycles each digit is lit (legal range 2..65535).
REQ-002 The block SHALL have parameter BLANK_CYC, default 4, giving the clock cycles all digits are dark between digits (legal range 1..255).
REQ-003 clk  input  1  the single clock, rising-edge active.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  1 = scanning enabled; 0 = display dark.
REQ-006 data  input  16  four hex digits; digit k = data[4k+3:4k], digit 0 rightmost.
REQ-007 dp_in  input  4  decimal point per digit, bit k for digit k, 1 = lit.
REQ-008 load_req  input  1  level request to capture data/dp_in into the shadow register.
REQ-009 load_ack  output  1  one-cycle pulse marking the capture.
REQ-010 a, b, c, d, e, f, g  output  1 each  segment drives, active-high.
REQ-011 dot  output  1  decimal-point drive, active-high.
REQ-012 an  output  4  digit enables, active-low, an[k] selects digit k.
REQ-013 frame_done  output  1  one-cycle pulse after digit 3 completes its blank phase.

Function
REQ-014 All outputs SHALL be registered; segment patterns SHALL come from an internal hex decoder applied to the shadow register, never to data directly.
REQ-015 Decoder {a,b,c,d,e,f,g} SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-016 FSM states SHALL be IDLE, SHOW, BLANK.
REQ-017 IDLE: an=1111, segments and dot 0, digit index 0, divider 0; en=1 SHALL move to SHOW with digit 0 on the next edge.
REQ-018 SHOW: an has only bit idx low, segments/dot show digit idx; after exactly DIV cycles, go to BLANK.
REQ-019 BLANK: an=1111, segments and dot 0; after exactly BLANK_CYC cycles, idx increments modulo 4 and FSM returns to SHOW.
REQ-020 On the BLANK exit where idx wraps 3->0, frame_done SHALL pulse for one cycle.
REQ-021 en=0 in any state SHALL force IDLE on the next edge, idx=0, divider cleared; no frame_done pulse.
REQ-022 Capture SHALL occur only in IDLE or on the idx 3->0 wrap cycle, so a frame never shows mixed data.
REQ-023 When load_req=1 at a capture point, data and dp_in SHALL be latched and load_ack SHALL pulse on that same edge.
REQ-024 The requester SHALL hold load_req and data stable until load_ack; a new request SHALL not be acknowledged until load_req has been seen low for at least one cycle.
REQ-025 load_req and en falling in the same cycle: the capture SHALL still occur (IDLE is a capture point).

Reset
REQ-026 rst_n low SHALL immediately force: FSM IDLE, idx 0, divider 0, shadow 0, an=1111, a..g=0, dot=0, load_ack=0, frame_done=0.
REQ-027 Reset deassertion mid-frame SHALL restart at digit 0 on the first enabled edge; no partial frame is resumed.

Configuration
REQ-028 With macro SEV_SEG_LZB_EN defined, leading-zero blanking SHALL apply: in SHOW, digits above the highest nonzero digit output segments 0000000 (an still driven, dot still honoured); digit 0 is always decoded.
REQ-029 Without SEV_SEG_LZB_EN, all four digits SHALL always be decoded; timing is identical in both builds.

Verification (DIV=4, BLANK_CYC=2)
REQ-030 Reset, en=1, load data=16'h12AF, dp_in=0 -> an sequence 1110(4 cyc), 1111(2), 1101(4), 1111(2), 1011(4), 1111(2), 0111(4), 1111(2); segments F, A, 2, 1; frame_done once per 24 cycles.
REQ-031 load_req mid-frame with data=16'h0005 -> load_ack only on the wrap cycle; the current frame finishes with the old value.
REQ-032 SEV_SEG_LZB_EN build, data=16'h0005 -> digits 3..1 segments 0000000, digit 0 1011011; non-LZB build shows 1111110 on digits 3..1.
REQ-033 en dropped during digit 2 SHOW -> an=1111 next cycle, no frame_done; re-enable restarts at digit 0.
REQ-034 rst_n asserted asynchronously mid-BLANK -> all outputs at reset values before the next clock edge.
